// File: rtl/cpu_pkg.sv
// Shared CPU definitions: reset/bubble constants, fetch FSM states and the PC source encoding.
package cpu_pkg;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fsm_state_t;

    // Bit 1 marks a redirect, so the control unit's flush line is pc_sel[1].
    typedef enum logic [1:0] {
        PC_SEL_INC   = 2'b00,
        PC_SEL_HOLD  = 2'b01,
        PC_SEL_REDIR = 2'b10
    } pc_sel_t;

endpackage

// File: rtl/perf_counter.sv
// Saturating event counter: counts enabled cycles, sticks at all-ones, no wrap.
// Result visible one edge after the enabled cycle; no backpressure.
module perf_counter #(
    parameter int CNT_W = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_cnt
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != '1)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: PC register, IF/ID register and perf counters; instruction reaches IF/ID one edge after PC.
// Stall holds PC and IF/ID; flush redirects the PC and bubbles IF/ID, winning over stall.
module if_stage
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = cpu_pkg::RESET_PC,
    parameter int          IMEM_DEPTH = 1024,
    parameter int          CNT_W      = 32,
    parameter logic [31:0] NOP_INSTR  = cpu_pkg::NOP_INSTR
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stall_i,
    input  logic             flush_i,
    input  logic [31:0]      target_i,
    output logic [31:0]      imem_addr_o,
    input  logic [31:0]      imem_data_i,
    output logic [31:0]      pc_o,
    output logic [31:0]      ifid_instr_o,
    output logic [31:0]      ifid_pc4_o,
    output logic             ifid_valid_o,
    output logic [CNT_W-1:0] cycle_cnt_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    // Memory aliasing relies on the word index being a plain bit slice of the PC.
    if ((IMEM_DEPTH < 1) || ((IMEM_DEPTH & (IMEM_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("if_stage: IMEM_DEPTH must be a power of two");
    end

    fsm_state_t r_state;
    fsm_state_t w_state_nxt;
    pc_sel_t    w_pc_sel;
    logic       w_ifid_ld;
    logic       w_ifid_bubble;
    logic       w_run;

    logic [31:0] r_pc;
    logic [31:0] r_ifid_instr;
    logic [31:0] r_ifid_pc4;
    logic        r_ifid_valid;
    logic [31:0] w_pc4;
    logic [31:0] w_target;

    assign w_pc4    = r_pc + 32'd4;
    assign w_target = target_i & 32'hFFFF_FFFC;
    assign w_run    = (r_state == RUN);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_pc_sel      = PC_SEL_HOLD;
        w_ifid_ld     = 1'b1;
        w_ifid_bubble = 1'b1;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (!start) begin
                    w_state_nxt = IDLE;
                end else if (flush_i) begin
                    w_pc_sel = PC_SEL_REDIR;
                end else if (stall_i) begin
                    w_ifid_ld = 1'b0;
                end else begin
                    w_pc_sel      = PC_SEL_INC;
                    w_ifid_bubble = 1'b0;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc <= RESET_PC;
        end else begin
            case (w_pc_sel)
                PC_SEL_INC:   r_pc <= w_pc4;
                PC_SEL_REDIR: r_pc <= w_target;
                default:      r_pc <= r_pc;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ifid_instr <= NOP_INSTR;
            r_ifid_pc4   <= 32'd0;
            r_ifid_valid <= 1'b0;
        end else if (w_ifid_ld) begin
            if (w_ifid_bubble) begin
                r_ifid_instr <= NOP_INSTR;
                r_ifid_pc4   <= 32'd0;
                r_ifid_valid <= 1'b0;
            end else begin
                r_ifid_instr <= imem_data_i;
                r_ifid_pc4   <= w_pc4;
                r_ifid_valid <= 1'b1;
            end
        end
    end

    perf_counter #(.CNT_W(CNT_W)) u_cycle_cnt (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_en    (w_run),
        .o_cnt   (cycle_cnt_o)
    );

    perf_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_en    (w_run && stall_i && !flush_i),
        .o_cnt   (stall_cnt_o)
    );

    perf_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_en    (w_run && flush_i),
        .o_cnt   (flush_cnt_o)
    );

    assign imem_addr_o  = r_pc;
    assign pc_o         = r_pc;
    assign ifid_instr_o = r_ifid_instr;
    assign ifid_pc4_o   = r_ifid_pc4;
    assign ifid_valid_o = r_ifid_valid;

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage pipelined CPU.
- Owns the PC register and the IF/ID pipeline register, and drives the instruction-memory address.
- Applies stall from the hazard detection unit and flush/redirect from the control unit.
- Maintains cycle, stall and flush performance counters, so the stall/flush statistics currently counted in the bench come from hardware.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- IMEM_DEPTH, 1024, instruction memory depth in 32-bit words.
- CNT_W, 32, performance counter width.
- NOP_INSTR, 32'h0000_0000, instruction inserted into IF/ID on bubble or flush.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  run enable; fetch advances only while high.
- stall_i  in  1  HDU stall; hold PC and IF/ID.
- flush_i  in  1  control flush (PC_ctrl[1]); redirect PC and squash IF/ID.
- target_i  in  32  redirect address (branch/jump target), valid with flush_i.
- imem_addr_o  out  32  byte address to instruction memory (= pc_o).
- imem_data_i  in  32  instruction word, combinational read of imem_addr_o.
- pc_o  out  32  current PC.
- ifid_instr_o  out  32  IF/ID instruction.
- ifid_pc4_o  out  32  IF/ID PC+4.
- ifid_valid_o  out  1  IF/ID holds a real instruction.
- cycle_cnt_o  out  CNT_W  cycles spent in RUN.
- stall_cnt_o  out  CNT_W  RUN cycles with stall_i=1 and flush_i=0.
- flush_cnt_o  out  CNT_W  RUN cycles with flush_i=1.

Behaviour:
- Reset (rst=0, async): pc_o=RESET_PC, ifid_instr_o=NOP_INSTR, ifid_pc4_o=0, ifid_valid_o=0, all counters 0, FSM=IDLE.
- FSM states:
  - IDLE: PC holds; each clock loads a bubble (NOP_INSTR, valid=0) into IF/ID. start=1 sampled at a rising edge -> RUN. No fetch occurs on that edge.
  - RUN: normal fetch. start=0 sampled -> IDLE. The edge that sees start=0 loads a bubble and holds the PC.
- RUN priority per rising edge, highest first:
  1. flush_i=1: pc <= {target_i[31:2],2'b00}; IF/ID <= bubble. Flush wins over a simultaneous stall.
  2. stall_i=1: pc and IF/ID hold all fields unchanged.
  3. Otherwise: IF/ID <= {imem_data_i, pc+4, valid=1}; pc <= pc+4.
- Latency: an instruction at PC n appears on ifid_instr_o one edge after pc_o=n, absent stall.
- Arithmetic:
  - pc+4 wraps modulo 2^32.
  - Instruction memory word index is pc[log2(IMEM_DEPTH)+1:2]. Upper bits are ignored, so addresses alias modulo IMEM_DEPTH*4.
- Counters:
  - Increment only in RUN; they freeze in IDLE.
  - Saturate at all-ones; no wrap.
  - A cycle with both stall_i and flush_i counts as flush only.
- Reset asserted mid-run returns every output to its reset value immediately, without waiting for a clock edge.
- stall_i and flush_i are ignored in IDLE.

Decomposition:
- cpu_pkg: NOP_INSTR, RESET_PC, the fsm_state_t enum {IDLE, RUN}, and a pc_sel encoding shared with the control unit.
- One sub-module: perf_counter, a saturating counter with enable; instantiated three times.

Test Plan:
- Reset then start=1, no hazards, imem[0..3]=A,B,C,D -> pc_o sequence 0,4,8,12. ifid_instr_o=A one edge after pc_o=0. cycle_cnt_o=4 after 4 edges.
- stall_i=1 for 2 cycles while pc_o=8 -> pc_o stays 8 and IF/ID keeps B for 2 edges, then resumes with C. stall_cnt_o=2.
- flush_i=1, target_i=32'h40 while pc_o=12 -> next pc_o=0x40, ifid_valid_o=0, ifid_instr_o=NOP. flush_cnt_o=1. Next edge fetches imem[16].
- stall_i=1 and flush_i=1 together, target_i=32'h22 -> pc_o=0x20 (alignment forced), IF/ID bubbled. flush_cnt_o increments and stall_cnt_o does not.
- start dropped mid-run at pc_o=20 -> PC holds at 20, bubbles enter IF/ID, counters freeze. Raising start resumes fetch from 20.
- rst pulsed low between edges during RUN with pc_o=0x40 -> outputs return to reset values immediately. Counter preset near max (saturation check via force) -> it holds at all-ones.
